// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_div_unit_pkg;

  // Controller states: accept an op, iterate, then apply signs and write HI/LO.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Operation select carried on the op port.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One combinational iteration: unsigned shift-add multiply or restoring divide.
// Latency: 0 (purely combinational).
// Backpressure: none; the caller decides when to register the result.
module md_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op_i,
  input  logic [2*WIDTH-1:0] acc_i,   // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  input  logic [WIDTH-1:0]   opnd_i,  // mult: multiplicand magnitude; div: divisor magnitude
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: add the multiplicand when the outgoing multiplier bit is set; carry lands in bit WIDTH.
  assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  // Divide: WIDTH+1-bit partial remainder shifted left with the next dividend bit.
  assign shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd_i};

  // Select the iteration result; the quotient bit is OR-ed into the LSB by the caller.
  always_comb begin
    acc_o   = acc_i;
    q_bit_o = 1'b0;
    if (op_i == OP_MULT) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (shifted >= {1'b0, opnd_i}) begin
      q_bit_o = 1'b1;
      acc_o   = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o   = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed WIDTHxWIDTH multiply and WIDTH/WIDTH divide producing MIPS HI/LO.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero answers in 1 cycle.
// Backpressure: one op in flight; start while busy is ignored.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               op_q;
  logic               neg_res_q;  // product / quotient sign
  logic               neg_rem_q;  // remainder follows the dividend
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // The unsigned reading of a WIDTH-bit two's-complement negation is exact even for the
  // most negative value, so 0x80000000 yields magnitude 2^31 without overflow.
  assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q)
  );

  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  // Control FSM plus all datapath and result registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_DIV && B == '0) begin
              // No iteration needed: flag it and leave HI/LO untouched.
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end else begin
              dz_q      <= 1'b0;
              cnt_q     <= '0;
              op_q      <= op;
              neg_res_q <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_rem_q <= A[WIDTH-1];
              // Mult shifts the multiplier out of the low half; div shifts the dividend out.
              acc_q     <= {{WIDTH{1'b0}}, (op == OP_DIV) ? a_mag : b_mag};
              opnd_q    <= (op == OP_DIV) ? b_mag : a_mag;
              state_q   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_q <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (op_q == OP_DIV) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed mult/div results, latency, div-by-zero,
// ignored start while busy, back-to-back start and mid-op reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int k_cyc  = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one start for one edge (edge k), return #1 after edge k with inputs scrambled.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    k_cyc = cyc;
    start = 1'b0;
    op    = 1'($urandom);
    A     = $urandom;
    B     = $urandom;
  endtask

  // Wait (bounded) for done, checking latency, busy during run and HI/LO stability.
  task automatic wait_done(input string tag, input logic [63:0] exp_hilo);
    logic        busy_ok;
    logic        stable;
    logic [31:0] h0;
    logic [31:0] l0;
    busy_ok = 1'b1;
    stable  = 1'b1;
    h0      = hi;
    l0      = lo;
    while (!done && (cyc - k_cyc) < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, 64'(cyc - k_cyc), 64'd33);
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, "_hilo_stable"}, 64'(stable), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, exp_hilo);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Signed multiplies
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("m1_busy_k", 64'(busy), 64'd1);
    wait_done("m1", 64'hFFFF_FFFF_FFFF_FFEB);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done("m2", 64'h4000_0000_0000_0000);
    issue(1'b0, 32'h1234_5678, 32'h10);
    wait_done("m3", 64'h0000_0001_2345_6780);

    // Signed divides: truncation toward zero, remainder follows dividend
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("d1", {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("d2", {32'h0, 32'h8000_0000});
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done("d3", {32'h1, 32'hFFFF_FFFD});
    issue(1'b1, 32'd100, 32'd7);
    wait_done("d4", {32'd2, 32'd14});

    // Divide by zero: done and flag right after the start edge, HI/LO kept
    issue(1'b1, 32'd5, 32'd0);
    chk("dz_done", 64'(done), 64'd1);
    chk("dz_flag", 64'(div_zero), 64'd1);
    chk("dz_busy", 64'(busy), 64'd0);
    chk("dz_hilo", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    chk("dz_done_pulse", 64'(done), 64'd0);
    chk("dz_flag_held", 64'(div_zero), 64'd1);
    chk("dz_busy2", 64'(busy), 64'd0);
    issue(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    chk("dz_cleared", 64'(div_zero), 64'd0);
    wait_done("m4", 64'd6);

    // Start while busy is ignored; start in the done cycle is accepted
    issue(1'b0, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    A     = 32'd99;
    B     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", 64'd15);
    issue(1'b1, 32'h7FFF_FFFF, 32'h10);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b", {32'hF, 32'h07FF_FFFF});

    // Reset during a divide aborts it and clears HI/LO
    issue(1'b1, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_dz", 64'(div_zero), 64'd0);
    chk("mrst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b1, 32'd1000, 32'd3);
    wait_done("post_rst", {32'd1, 32'd333});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
